// File: rtl/lcd_persistence_pkg.sv
// Shared types and the per-cell decay/hysteresis step for the LCD persistence engine.
package lcd_persistence_pkg;

    localparam int MAX_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SWEEP,
        ST_SNAP
    } state_t;

    typedef struct packed {
        logic [MAX_DW-1:0] d;
        logic              disp;
    } cell_t;

    // Saturating step in integer space so neither end can wrap, then hysteresis on the new value.
    function automatic cell_t decay_next(
        input logic              live,
        input logic              en,
        input logic              disp,
        input logic [MAX_DW-1:0] d,
        input int                dw,
        input int                rise,
        input int                fall,
        input int                th_on,
        input int                th_off
    );
        cell_t r;
        int    max_v;
        int    nd;
        max_v  = (1 << dw) - 1;
        r.disp = disp;
        if (!en) begin
            nd     = live ? max_v : 0;
            r.disp = live;
        end else begin
            if (live) begin
                nd = int'(d) + rise;
                if (nd > max_v) nd = max_v;
            end else begin
                nd = int'(d) - fall;
                if (nd < 0) nd = 0;
            end
            if (nd >= th_on) begin
                r.disp = 1'b1;
            end else if (nd <= th_off) begin
                r.disp = 1'b0;
            end
        end
        r.d = MAX_DW'(nd);
        return r;
    endfunction

endpackage

// File: rtl/lcd_decay_cell.sv
// Combinational update of one segment cell: decay counter step plus display hysteresis.
module lcd_decay_cell
    import lcd_persistence_pkg::*;
#(
    parameter int DECAY_W    = 5,
    parameter int RISE       = 1,
    parameter int FALL       = 1,
    parameter int THRESH_ON  = 17,
    parameter int THRESH_OFF = 16
) (
    input  logic               live,
    input  logic               decay_en,
    input  logic [DECAY_W-1:0] d,
    input  logic               disp,
    output logic [DECAY_W-1:0] d_nxt,
    output logic               disp_nxt
);

    cell_t res;
    logic  unused_hi;

    always_comb begin
        res = decay_next(live, decay_en, disp, MAX_DW'(d), DECAY_W, RISE, FALL,
                         THRESH_ON, THRESH_OFF);
    end

    // The step saturates at 2^DECAY_W-1, so bits above DECAY_W are always zero.
    assign d_nxt     = res.d[DECAY_W-1:0];
    assign disp_nxt  = res.disp;
    assign unused_hi = |(res.d >> DECAY_W);

endmodule

// File: rtl/lcd_persistence.sv
// LCD segment persistence engine: live segment store, LANES-wide decay sweep per tick,
// and a frame-coherent snapshot of the display bits on vblank.
module lcd_persistence
    import lcd_persistence_pkg::*;
#(
    parameter int NUM_H      = 4,
    parameter int SEGS       = 16,
    parameter int DECAY_W    = 5,
    parameter int RISE       = 1,
    parameter int FALL       = 1,
    parameter int THRESH_ON  = 17,
    parameter int THRESH_OFF = 16,
    parameter int LANES      = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     seg_wr,
    input  logic [$clog2(NUM_H)-1:0] seg_h,
    input  logic [SEGS-1:0]          seg_in,
    input  logic                     tick,
    input  logic                     decay_en,
    input  logic                     vblank,
    output logic [NUM_H*SEGS-1:0]    seg_out,
    output logic                     busy,
    output logic                     overrun
);

    localparam int CELLS = NUM_H * SEGS;
    localparam int IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CELLS - LANES);

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CELLS-1:0]   live_q, live_d;
    logic [DECAY_W-1:0] decay_q [CELLS];
    logic [DECAY_W-1:0] decay_d [CELLS];
    logic [CELLS-1:0]   disp_q, disp_d;
    logic [CELLS-1:0]   seg_out_q, seg_out_d;
    logic               tick_prev_q, tick_prev_d;
    logic               vblank_prev_q, vblank_prev_d;
    logic               tick_pending_q, tick_pending_d;
    logic               snap_pending_q, snap_pending_d;
    logic               overrun_q, overrun_d;

    logic               tick_edge;
    logic               vblank_edge;

    logic               lane_live     [LANES];
    logic [DECAY_W-1:0] lane_d        [LANES];
    logic               lane_disp     [LANES];
    logic [DECAY_W-1:0] lane_d_nxt    [LANES];
    logic               lane_disp_nxt [LANES];

    assign tick_edge   = tick & ~tick_prev_q;
    assign vblank_edge = vblank & ~vblank_prev_q;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_live[l] = live_q[idx_q + IDX_W'(l)];
        assign lane_d[l]    = decay_q[idx_q + IDX_W'(l)];
        assign lane_disp[l] = disp_q[idx_q + IDX_W'(l)];

        lcd_decay_cell #(
            .DECAY_W    (DECAY_W),
            .RISE       (RISE),
            .FALL       (FALL),
            .THRESH_ON  (THRESH_ON),
            .THRESH_OFF (THRESH_OFF)
        ) u_cell (
            .live     (lane_live[l]),
            .decay_en (decay_en),
            .d        (lane_d[l]),
            .disp     (lane_disp[l]),
            .d_nxt    (lane_d_nxt[l]),
            .disp_nxt (lane_disp_nxt[l])
        );
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        live_d         = live_q;
        decay_d        = decay_q;
        disp_d         = disp_q;
        seg_out_d      = seg_out_q;
        tick_prev_d    = tick;
        vblank_prev_d  = vblank;
        tick_pending_d = tick_pending_q;
        snap_pending_d = snap_pending_q;
        overrun_d      = overrun_q;

        if (seg_wr && (int'(seg_h) < NUM_H)) begin
            live_d[int'(seg_h)*SEGS +: SEGS] = seg_in;
        end

        // Edges seen while busy are queued; a second queued tick is lost and flagged.
        if (state_q != ST_IDLE) begin
            if (tick_edge) begin
                if (tick_pending_q) overrun_d = 1'b1;
                else                tick_pending_d = 1'b1;
            end
            if (vblank_edge) snap_pending_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (tick_edge || tick_pending_q) begin
                    state_d        = ST_SWEEP;
                    idx_d          = '0;
                    tick_pending_d = tick_pending_q && tick_edge;
                    if (vblank_edge) snap_pending_d = 1'b1;
                end else if (vblank_edge || snap_pending_q) begin
                    state_d = ST_SNAP;
                end
            end
            ST_SWEEP: begin
                for (int l = 0; l < LANES; l++) begin
                    decay_d[idx_q + IDX_W'(l)] = lane_d_nxt[l];
                    disp_d[idx_q + IDX_W'(l)]  = lane_disp_nxt[l];
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = snap_pending_d ? ST_SNAP : ST_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(LANES);
                end
            end
            ST_SNAP: begin
                seg_out_d      = disp_q;
                snap_pending_d = vblank_edge;
                state_d        = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            idx_q          <= '0;
            live_q         <= '0;
            disp_q         <= '0;
            seg_out_q      <= '0;
            tick_prev_q    <= 1'b0;
            vblank_prev_q  <= 1'b0;
            tick_pending_q <= 1'b0;
            snap_pending_q <= 1'b0;
            overrun_q      <= 1'b0;
            for (int i = 0; i < CELLS; i++) decay_q[i] <= '0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            live_q         <= live_d;
            disp_q         <= disp_d;
            seg_out_q      <= seg_out_d;
            tick_prev_q    <= tick_prev_d;
            vblank_prev_q  <= vblank_prev_d;
            tick_pending_q <= tick_pending_d;
            snap_pending_q <= snap_pending_d;
            overrun_q      <= overrun_d;
            for (int i = 0; i < CELLS; i++) decay_q[i] <= decay_d[i];
        end
    end

    assign seg_out = seg_out_q;
    assign busy    = (state_q == ST_SWEEP);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_lcd_persistence.sv
// Self-checking bench for lcd_persistence: stimulus tasks drive the DUT and checkOutput
// compares the settled registered outputs against hand-computed expectations.
module tb_lcd_persistence;

   localparam int OP_WRITE  = 0;
   localparam int OP_TICK   = 1;
   localparam int OP_VBLANK = 2;

   localparam int SIG_SEG  = 0;
   localparam int SIG_BUSY = 1;
   localparam int SIG_OVR  = 2;
   localparam int SIG_WAIT = 3;

   localparam logic [63:0] ALL = 64'hFFFF_FFFF_FFFF_FFFF;

   logic        clk;
   logic        reset_n;
   logic        seg_wr;
   logic [1:0]  seg_h;
   logic [15:0] seg_in;
   logic        tick;
   logic        decay_en;
   logic        vblank;
   logic [63:0] seg_out;
   logic        busy;
   logic        overrun;

   int          num_checks;
   int          num_fail;

   lcd_persistence dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .seg_wr   (seg_wr),
      .seg_h    (seg_h),
      .seg_in   (seg_in),
      .tick     (tick),
      .decay_en (decay_en),
      .vblank   (vblank),
      .seg_out  (seg_out),
      .busy     (busy),
      .overrun  (overrun)
   );

   // Free-running clock with a 10-unit period.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compares one output class against its expectation right away; outputs are registered and settled.
   task automatic checkOutput(input string name, input int sig, input logic [63:0] mask,
                              input logic [63:0] expv, input logic [63:0] aux = 64'd0);
      num_checks++;
      if (sig == SIG_SEG) begin
         if ((seg_out & mask) !== expv) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, seg_out & mask, expv);
         end
      end else if (sig == SIG_BUSY) begin
         if (busy !== expv[0]) begin
            num_fail++;
            $display("[TB] FAIL %s: got %b expected %b", name, busy, expv[0]);
         end
      end else if (sig == SIG_OVR) begin
         if (overrun !== expv[0]) begin
            num_fail++;
            $display("[TB] FAIL %s: got %b expected %b", name, overrun, expv[0]);
         end
      end else begin
         if (aux !== expv) begin
            num_fail++;
            $display("[TB] FAIL %s: got %h expected %h", name, aux, expv);
         end
      end
   endtask

   task automatic waitIdle(input string name);
      int n = 0;
      while (busy && n < 64) begin
         @(posedge clk); #1;
         n++;
      end
      checkOutput({name, "_wait"}, SIG_WAIT, ALL, 64'd0, {63'd0, busy});
   endtask

   task automatic applyStimulus(input int op, input int h = 0, input logic [15:0] data = 16'h0);
      case (op)
         OP_WRITE: begin
            seg_wr = 1'b1;
            seg_h  = 2'(h);
            seg_in = data;
            @(posedge clk); #1;
            seg_wr = 1'b0;
         end
         OP_TICK: begin
            tick = 1'b1;
            @(posedge clk); #1;
            tick = 1'b0;
            waitIdle("tick");
         end
         default: begin
            vblank = 1'b1;
            @(posedge clk); #1;
            vblank = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
         end
      endcase
   endtask

   task automatic runTicks(input int n);
      for (int i = 0; i < n; i++) applyStimulus(OP_TICK);
   endtask

   // Main sequence: reset, decay rise/fall/saturation, bypass, deferred snapshot, overrun.
   initial begin
      num_checks = 0;
      num_fail   = 0;
      reset_n    = 1'b0;
      seg_wr     = 1'b0;
      seg_h      = 2'd0;
      seg_in     = 16'h0;
      tick       = 1'b0;
      decay_en   = 1'b1;
      vblank     = 1'b0;

      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_seg_out", SIG_SEG, ALL, 64'd0);
      checkOutput("rst_busy", SIG_BUSY, ALL, 64'd0);
      checkOutput("rst_overrun", SIG_OVR, ALL, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;

      applyStimulus(OP_WRITE, 0, 16'h0001);
      runTicks(16);
      applyStimulus(OP_VBLANK);
      checkOutput("rise16", SIG_SEG, ALL, 64'd0);
      runTicks(1);
      applyStimulus(OP_VBLANK);
      checkOutput("rise17", SIG_SEG, ALL, 64'h1);

      runTicks(23);
      applyStimulus(OP_VBLANK);
      checkOutput("sat40", SIG_SEG, ALL, 64'h1);

      applyStimulus(OP_WRITE, 0, 16'h0000);
      runTicks(14);
      applyStimulus(OP_VBLANK);
      checkOutput("hyst17", SIG_SEG, ALL, 64'h1);
      runTicks(1);
      applyStimulus(OP_VBLANK);
      checkOutput("fall16", SIG_SEG, ALL, 64'd0);

      runTicks(40);
      applyStimulus(OP_VBLANK);
      checkOutput("floor40", SIG_SEG, ALL, 64'd0);
      applyStimulus(OP_WRITE, 0, 16'h0001);
      runTicks(16);
      applyStimulus(OP_VBLANK);
      checkOutput("refill16", SIG_SEG, ALL, 64'd0);
      runTicks(1);
      applyStimulus(OP_VBLANK);
      checkOutput("refill17", SIG_SEG, ALL, 64'h1);

      decay_en = 1'b0;
      applyStimulus(OP_WRITE, 3, 16'hA5A5);
      runTicks(1);
      applyStimulus(OP_VBLANK);
      checkOutput("bypass_h3", SIG_SEG, 64'hFFFF_0000_0000_0000, 64'hA5A5_0000_0000_0000);
      checkOutput("bypass_all", SIG_SEG, ALL, 64'hA5A5_0000_0000_0001);

      applyStimulus(OP_WRITE, 1, 16'hFFFF);
      tick = 1'b1;
      @(posedge clk); #1;
      tick = 1'b0;
      for (int c = 1; c <= 17; c++) begin
         if (c == 5) vblank = 1'b1;
         if (c == 6) vblank = 1'b0;
         checkOutput($sformatf("defer_seg_c%0d", c), SIG_SEG, ALL, 64'hA5A5_0000_0000_0001);
         checkOutput($sformatf("defer_busy_c%0d", c), SIG_BUSY, ALL, (c <= 16) ? 64'd1 : 64'd0);
         @(posedge clk); #1;
      end
      checkOutput("defer_snap", SIG_SEG, ALL, 64'hA5A5_0000_FFFF_0001);

      applyStimulus(OP_WRITE, 2, 16'h00FF);
      tick   = 1'b1;
      vblank = 1'b1;
      @(posedge clk); #1;
      tick   = 1'b0;
      vblank = 1'b0;
      checkOutput("both_pre", SIG_SEG, ALL, 64'hA5A5_0000_FFFF_0001);
      waitIdle("both");
      @(posedge clk); #1;
      checkOutput("both_snap", SIG_SEG, ALL, 64'hA5A5_00FF_FFFF_0001);
      @(posedge clk); #1;

      tick = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         tick = (c == 2 || c == 4);
         if (c == 4)  checkOutput("ovr_before", SIG_OVR, ALL, 64'd0);
         if (c == 5)  checkOutput("ovr_set", SIG_OVR, ALL, 64'd1);
         if (c == 16) checkOutput("sweep1_last", SIG_BUSY, ALL, 64'd1);
         if (c == 17) checkOutput("sweep1_gap", SIG_BUSY, ALL, 64'd0);
         if (c == 18) checkOutput("sweep2_start", SIG_BUSY, ALL, 64'd1);
         if (c == 33) checkOutput("sweep2_last", SIG_BUSY, ALL, 64'd1);
         if (c == 34) checkOutput("sweep2_end", SIG_BUSY, ALL, 64'd0);
         if (c == 40) checkOutput("no_sweep3", SIG_BUSY, ALL, 64'd0);
         if (c == 40) checkOutput("ovr_sticky", SIG_OVR, ALL, 64'd1);
      end

      reset_n = 1'b0;
      #1;
      checkOutput("rst2_overrun", SIG_OVR, ALL, 64'd0);
      checkOutput("rst2_seg_out", SIG_SEG, ALL, 64'd0);
      checkOutput("rst2_busy", SIG_BUSY, ALL, 64'd0);
      @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;

      if (num_fail == 0 && num_checks >= 12) begin
         $display("[TB] PASS: %0d checks, %0d failures", num_checks, num_fail);
      end else begin
         $display("[TB] FAIL summary: got %0d failures in %0d checks expected 0", num_fail, num_checks);
      end
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
      $finish;
   end

   // Watchdog so a hung DUT cannot stall the run forever.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/lcd_persistence.md
Name: lcd_persistence

Overview:
- Parametrised LCD segment persistence engine for the Game & Watch video path.
- Keeps the last-written segment state for every H (common) phase and runs a saturating decay counter per segment cell, stepped on each 1 kHz tick.
- Produces display bits with on/off hysteresis and hands a frame-coherent copy to the segment renderer on the vblank rising edge.
- Successor to the fixed 4-H / 16-segment parallel decay logic: cells are swept LANES-at-a-time by a small FSM, with configurable rates and thresholds, a bypass mode and tick-overrun handling.

Parameters:
- NUM_H, 4, number of H phases (commons)
- SEGS, 16, segment bits per H
- DECAY_W, 5, decay counter width
- RISE, 1, increment per tick while the segment is driven
- FALL, 1, decrement per tick while the segment is undriven
- THRESH_ON, 17, display bit sets when decay >= THRESH_ON
- THRESH_OFF, 16, display bit clears when decay <= THRESH_OFF; requires THRESH_OFF < THRESH_ON
- LANES, 4, cells updated per sweep cycle; must divide NUM_H*SEGS

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- seg_wr  in  1  write strobe for live segment state
- seg_h  in  $clog2(NUM_H)  H index being written
- seg_in  in  SEGS  segment levels for seg_h
- tick  in  1  1 kHz divider level; its rising edge starts a sweep
- decay_en  in  1  0 = bypass (display follows live state directly)
- vblank  in  1  vblank level; its rising edge snapshots the display bits
- seg_out  out  NUM_H*SEGS  frame-latched display bits, H-major (bit h*SEGS+s)
- busy  out  1  sweep in progress
- overrun  out  1  sticky: a tick edge was dropped

Behaviour:
- Reset (asynchronous): all live bits, decay counters, display bits, seg_out, busy, overrun, pending flags and edge-detect registers go to 0.
- Live array:
  - When seg_wr is high, live[seg_h] <= seg_in on the next clk.
  - seg_h >= NUM_H is ignored.
  - Live writes are accepted during a sweep; the sweep reads the live value current in the cycle it visits each cell.
- Edge detection: tick and vblank each pass through one register. An edge is curr & ~prev.
- FSM states: IDLE, SWEEP, SNAP.
- IDLE:
  - Tick edge (or tick_pending) -> SWEEP; clear tick_pending; cell index idx = 0; busy = 1 in the following cycle.
  - Otherwise, vblank edge (or snap_pending) -> SNAP.
- SWEEP:
  - Each cycle updates cells idx..idx+LANES-1, then idx += LANES.
  - After the final group (idx = NUM_H*SEGS-LANES) -> SNAP if snap_pending, else IDLE.
  - Sweep length is NUM_H*SEGS/LANES cycles.
- Cell update with decay_en = 1:
  - Live = 1: d' = min(d+RISE, 2^DECAY_W-1).
  - Live = 0: d' = max(d-FALL, 0).
  - Compute at DECAY_W+1 bits; no wrap.
  - Display bit is computed from d', not the old d:
    - set if d' >= THRESH_ON;
    - cleared if d' <= THRESH_OFF;
    - otherwise held.
- Cell update with decay_en = 0: d' = live ? max : 0; display = live.
- SNAP: seg_out <= display array in one cycle, then clear snap_pending and go to IDLE. seg_out changes only in SNAP.
- Tick edge during SWEEP:
  - If tick_pending = 0, set it. The new sweep starts directly after the current sweep completes (and after any SNAP).
  - If tick_pending is already 1, set overrun. overrun clears only on reset.
- Vblank edge during SWEEP or SNAP sets snap_pending. The snapshot is deferred so seg_out never mixes pre- and post-sweep cells.
- Tick edge and vblank edge in the same IDLE cycle: sweep first, then SNAP (snap_pending set).
- Reset asserted mid-sweep aborts the sweep; all state returns to reset values.

Decomposition:
- Package lcd_persistence_pkg holds:
  - FSM state enum (IDLE/SWEEP/SNAP)
  - decay_next function (saturating step plus hysteresis), parameterised by width/rates/thresholds through the module's parameters
- Sub-module lcd_decay_cell: combinational single-cell update (live, decay_en, d, disp -> d', disp'), instantiated LANES times.

Test Plan:
- Reset, seg_wr h=0 seg_in=16'h0001, 17 tick edges, then vblank edge -> seg_out[0]=1. After only 16 ticks it is 0, since decay=16 < 17.
- From decay=31, bit driven 0: 14 ticks -> decay=17, bit still 1 (hysteresis); 15th tick -> decay=16, bit 0 after the next vblank.
- Bit held 1 for 40 ticks -> decay saturates at 31, no wrap. Bit held 0 for 40 ticks -> decay holds at 0.
- decay_en=0, write h=3 seg_in=16'hA5A5, one tick, one vblank -> seg_out[63:48]=16'hA5A5 immediately after the single sweep.
- Vblank edge in sweep cycle 5 of 16 (defaults) -> seg_out unchanged until the cycle after the sweep ends, and then reflects all 64 updated cells.
- Three tick edges within one sweep -> two sweeps run back to back, overrun=1, and it stays 1 until reset_n falls.
